// File: rtl/ir_frame_rx.sv
// ==========================================================================
// Module      : ir_frame_rx
// Description : IR remote frame receiver. Measures the mark and space widths
//               of the leader/35-bit/connect/32-bit/stop frame and decodes it.
// Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

module ir_frame_rx #(
    parameter int T_LEAD_MARK_MIN  = 1000000,
    parameter int T_LEAD_MARK_MAX  = 1250000,
    parameter int T_LEAD_SPACE_MIN = 500000,
    parameter int T_LEAD_SPACE_MAX = 625000,
    parameter int T_MARK_MIN       = 37500,
    parameter int T_MARK_MAX       = 112500,
    parameter int T_ZERO_MIN       = 37500,
    parameter int T_ZERO_MAX       = 112500,
    parameter int T_ONE_MIN        = 150000,
    parameter int T_ONE_MAX        = 250000,
    parameter int T_CONN_MIN       = 2250000,
    parameter int T_CONN_MAX       = 2750000,
    parameter int T_TIMEOUT        = 3125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_in,
    output logic [34:0] data35_out,
    output logic [31:0] data32_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy,
    output logic        led_out
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LEAD_MARK  = 4'd1,
        LEAD_SPACE = 4'd2,
        D35_MARK   = 4'd3,
        D35_SPACE  = 4'd4,
        CONN_MARK  = 4'd5,
        CONN_SPACE = 4'd6,
        D32_MARK   = 4'd7,
        D32_SPACE  = 4'd8,
        STOP_MARK  = 4'd9
    } state_t;

    state_t      state, state_n;
    logic        s1, s2, prev;
    logic [21:0] cnt;
    logic [5:0]  bitcnt, bitcnt_n;
    logic [34:0] shift35, shift35_n;
    logic [31:0] shift32, shift32_n;
    logic        valid_n, err_n, load;
    logic        fall, rise, timeout;

    function automatic logic in_win(input logic [21:0] w, input logic [21:0] lo,
                                    input logic [21:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    assign fall    = prev & ~s2;
    assign rise    = ~prev & s2;
    assign timeout = (cnt == T_TIMEOUT[21:0]);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
            cnt  <= '0;
        end else begin
            s1   <= ir_in;
            s2   <= s1;
            prev <= s2;
            if (fall || rise)
                cnt <= '0;
            else if (!timeout)
                cnt <= cnt + 22'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bitcnt      <= '0;
            shift35     <= '0;
            shift32     <= '0;
            data35_out  <= '0;
            data32_out  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            led_out     <= 1'b0;
        end else begin
            state       <= state_n;
            bitcnt      <= bitcnt_n;
            shift35     <= shift35_n;
            shift32     <= shift32_n;
            frame_valid <= valid_n;
            frame_err   <= err_n;
            if (load) begin
                data35_out <= shift35;
                data32_out <= shift32;
                led_out    <= ~led_out;
            end
        end
    end

    always_comb begin
        state_n   = state;
        bitcnt_n  = bitcnt;
        shift35_n = shift35;
        shift32_n = shift32;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_n   = LEAD_MARK;
                    bitcnt_n  = '0;
                    shift35_n = '0;
                    shift32_n = '0;
                end
            end
            LEAD_MARK: begin
                if (rise && in_win(cnt, T_LEAD_MARK_MIN[21:0], T_LEAD_MARK_MAX[21:0]))
                    state_n = LEAD_SPACE;
                else if (rise || timeout)
                    err_n = 1'b1;
            end
            LEAD_SPACE: begin
                if (fall && in_win(cnt, T_LEAD_SPACE_MIN[21:0], T_LEAD_SPACE_MAX[21:0]))
                    state_n = D35_MARK;
                else if (fall || timeout)
                    err_n = 1'b1;
            end
            D35_MARK, D32_MARK, CONN_MARK, STOP_MARK: begin
                if (rise && in_win(cnt, T_MARK_MIN[21:0], T_MARK_MAX[21:0])) begin
                    case (state)
                        D35_MARK:  state_n = D35_SPACE;
                        D32_MARK:  state_n = D32_SPACE;
                        CONN_MARK: state_n = CONN_SPACE;
                        default: begin
                            state_n = IDLE;
                            valid_n = 1'b1;
                            load    = 1'b1;
                        end
                    endcase
                end else if (rise || timeout)
                    err_n = 1'b1;
            end
            D35_SPACE, D32_SPACE: begin
                if (fall && (in_win(cnt, T_ZERO_MIN[21:0], T_ZERO_MAX[21:0]) ||
                             in_win(cnt, T_ONE_MIN[21:0], T_ONE_MAX[21:0]))) begin
                    // A width inside the zero window is a 0; otherwise it is a 1.
                    bitcnt_n = bitcnt + 6'd1;
                    if (state == D35_SPACE) begin
                        shift35_n = {shift35[33:0],
                                     ~in_win(cnt, T_ZERO_MIN[21:0], T_ZERO_MAX[21:0])};
                        state_n   = (bitcnt == 6'd34) ? CONN_MARK : D35_MARK;
                    end else begin
                        shift32_n = {shift32[30:0],
                                     ~in_win(cnt, T_ZERO_MIN[21:0], T_ZERO_MAX[21:0])};
                        state_n   = (bitcnt == 6'd31) ? STOP_MARK : D32_MARK;
                    end
                end else if (fall || timeout)
                    err_n = 1'b1;
            end
            CONN_SPACE: begin
                if (fall && in_win(cnt, T_CONN_MIN[21:0], T_CONN_MAX[21:0])) begin
                    state_n  = D32_MARK;
                    bitcnt_n = '0;
                end else if (fall || timeout)
                    err_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (err_n)
            state_n = IDLE;
    end

endmodule

`default_nettype wire

// File: tb/tb_ir_frame_rx.sv
// ==========================================================================
// Module      : tb_ir_frame_rx
// Description : Directed self-checking bench for ir_frame_rx with scaled timing.
// Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

module tb_ir_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ir_in = 1'b1;
    logic [34:0] data35_out;
    logic [31:0] data32_out;
    logic        frame_valid, frame_err, busy, led_out;

    int checks = 0;
    int failures = 0;
    int nv = 0, ne = 0, both = 0, wide = 0;
    logic pv = 1'b0, pe = 1'b0;

    localparam logic [34:0] D35_A = 35'b10000010000100000000010000001010010;
    localparam logic [31:0] D32_A = 32'b00001000000001000000000000000110;
    localparam logic [31:0] D32_B = 32'hA5C3_0F81;
    localparam logic [31:0] D32_C = 32'h1234_FEDC;

    // Timing scaled by 1/10000 to keep simulation short.
    ir_frame_rx #(
        .T_LEAD_MARK_MIN(100), .T_LEAD_MARK_MAX(125),
        .T_LEAD_SPACE_MIN(50), .T_LEAD_SPACE_MAX(62),
        .T_MARK_MIN(4),        .T_MARK_MAX(11),
        .T_ZERO_MIN(4),        .T_ZERO_MAX(11),
        .T_ONE_MIN(15),        .T_ONE_MAX(25),
        .T_CONN_MIN(225),      .T_CONN_MAX(275),
        .T_TIMEOUT(312)
    ) dut (
        .clk(clk), .rst(rst), .ir_in(ir_in),
        .data35_out(data35_out), .data32_out(data32_out),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .busy(busy), .led_out(led_out)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) nv++;
        if (frame_err) ne++;
        if (frame_valid && frame_err) both++;
        if ((frame_valid && pv) || (frame_err && pe)) wide++;
        pv = frame_valid;
        pe = frame_err;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Hold a level so the receiver measures width w (counter reads w at the edge).
    task automatic level(input logic v, input int w);
        ir_in = v;
        repeat (w + 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        ir_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // bad_bit: index into data35 whose space is stretched to 26; rst_bit: data32
    // bit during whose mark reset is pulsed. -1 disables either.
    task automatic send_frame(input logic [34:0] d35, input logic [31:0] d32,
                              input int one_w, input int bad_bit, input int rst_bit);
        level(1'b0, 112);
        level(1'b1, 56);
        for (int i = 0; i < 35; i++) begin
            level(1'b0, 7);
            if (i == bad_bit) begin
                level(1'b1, 26);
                level(1'b0, 7);
                idle(20);
                return;
            end
            level(1'b1, d35[34-i] ? one_w : 7);
        end
        level(1'b0, 7);
        level(1'b1, 250);
        for (int j = 0; j < 32; j++) begin
            if (j == rst_bit) begin
                level(1'b0, 3);
                rst   = 1'b1;
                ir_in = 1'b1;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                rst = 1'b0;
                idle(20);
                return;
            end
            level(1'b0, 7);
            level(1'b1, d32[31-j] ? one_w : 7);
        end
        level(1'b0, 7);
        idle(20);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        check("rst_d35", data35_out, 0);
        check("rst_d32", data32_out, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_led", led_out, 0);

        send_frame(D35_A, D32_A, 17, -1, -1);
        check("a_nv", nv, 1);
        check("a_ne", ne, 0);
        check("a_d35", data35_out, D35_A);
        check("a_d32", data32_out, D32_A);
        check("a_led", led_out, 1);
        check("a_busy", busy, 0);

        send_frame(D35_A, D32_A, 25, -1, -1);
        check("max1_nv", nv, 2);
        check("max1_ne", ne, 0);
        check("max1_d32", data32_out, D32_A);
        check("max1_led", led_out, 0);

        send_frame(D35_A, D32_B, 25, 6, -1);
        check("over1_ne", ne, 1);
        check("over1_nv", nv, 2);
        check("over1_d35", data35_out, D35_A);
        check("over1_d32", data32_out, D32_A);
        check("over1_busy", busy, 0);

        level(1'b0, 70);
        idle(20);
        check("shortlead_ne", ne, 2);
        send_frame(D35_A, D32_B, 17, -1, -1);
        check("after_lead_nv", nv, 3);
        check("after_lead_d32", data32_out, D32_B);
        check("after_lead_led", led_out, 1);

        level(1'b0, 112);
        level(1'b1, 56);
        ir_in = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("stuck_busy_mid", busy, 1);
        check("stuck_ne_mid", ne, 2);
        repeat (30) @(posedge clk);
        #1;
        check("stuck_ne", ne, 3);
        check("stuck_busy", busy, 0);
        idle(20);

        send_frame(D35_A, D32_C, 17, -1, 20);
        check("rst_mid_d35", data35_out, 0);
        check("rst_mid_d32", data32_out, 0);
        check("rst_mid_led", led_out, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_nv", nv, 3);
        check("rst_mid_ne", ne, 3);
        send_frame(D35_A, D32_C, 17, -1, -1);
        check("post_rst_nv", nv, 4);
        check("post_rst_d32", data32_out, D32_C);
        check("post_rst_led", led_out, 1);

        send_frame(D35_A, D32_B, 17, -1, -1);
        check("b2b1_d32", data32_out, D32_B);
        check("b2b1_led", led_out, 0);
        send_frame(D35_A, D32_C, 17, -1, -1);
        check("b2b2_d32", data32_out, D32_C);
        check("b2b2_d35", data35_out, D35_A);
        check("b2b2_led", led_out, 1);
        check("b2b_nv", nv, 6);
        check("final_ne", ne, 3);
        check("overlap", both, 0);
        check("pulse_width", wide, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
